// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the streaming SDF FFT: admits one FFT_N-sample frame per start,
// flushes the delay lines with zeros, then forwards FFT_N output bins with their index.
module fft_frame_ctrl #(
    parameter int OW        = 25,
    parameter int FFT_N     = 1024,
    parameter int FFT_NLOG2 = 10,
    parameter int FLUSH_MAX = 4096,
    parameter int DROPW     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic                 in_valid_i,
    input  logic [OW-1:0]        in_data_i,
    output logic                 fft_ce_o,
    output logic [OW-1:0]        fft_re_o,
    output logic [OW-1:0]        fft_im_o,
    input  logic                 fft_sync_i,
    input  logic [FFT_NLOG2-1:0] fft_cnt_i,
    input  logic [OW-1:0]        fft_re_i,
    input  logic [OW-1:0]        fft_im_i,
    output logic                 out_valid_o,
    output logic [OW-1:0]        out_re_o,
    output logic [OW-1:0]        out_im_o,
    output logic [FFT_NLOG2-1:0] out_bin_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic [DROPW-1:0]     drop_cnt_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam int TW = (FLUSH_MAX > 1) ? $clog2(FLUSH_MAX) : 1;
    localparam logic [FFT_NLOG2-1:0] FILL_LAST  = FFT_NLOG2'(FFT_N - 1);
    localparam logic [FFT_NLOG2:0]   DRAIN_LAST = (FFT_NLOG2 + 1)'(FFT_N - 1);
    localparam logic [FFT_NLOG2:0]   DRAIN_END  = (FFT_NLOG2 + 1)'(FFT_N);
    localparam logic [TW-1:0]        TMO_LAST   = TW'(FLUSH_MAX - 1);

    state_t               state_q;
    logic [FFT_NLOG2-1:0] fill_cnt_q;
    logic [TW-1:0]        tmo_cnt_q;
    logic [FFT_NLOG2:0]   drain_cnt_q;
    logic                 fft_ce_q;
    logic [OW-1:0]        fft_re_q;
    logic                 out_valid_q;
    logic [OW-1:0]        out_re_q;
    logic [OW-1:0]        out_im_q;
    logic [FFT_NLOG2-1:0] out_bin_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic [DROPW-1:0]     drop_cnt_q;
    logic [DROPW-1:0]     drop_cnt_d;

    // in_valid_i has no ready: a sample is taken only in FILL; any other valid cycle is a drop.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_valid_i && (state_q != S_FILL) && (drop_cnt_q != {DROPW{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            fill_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            drain_cnt_q <= '0;
            fft_ce_q    <= 1'b0;
            fft_re_q    <= '0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_bin_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    fft_ce_q <= 1'b0;
                    fft_re_q <= '0;
                    if (start_i) begin
                        state_q    <= S_FILL;
                        fill_cnt_q <= '0;
                        err_q      <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_FILL: begin
                    // The FFT only advances on accepted samples, so input gaps hold the pipeline.
                    fft_ce_q <= in_valid_i;
                    fft_re_q <= in_valid_i ? in_data_i : '0;
                    if (in_valid_i) begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                        if (fill_cnt_q == FILL_LAST) begin
                            state_q   <= S_FLUSH;
                            tmo_cnt_q <= '0;
                        end
                    end
                end
                S_FLUSH: begin
                    fft_re_q <= '0;
                    if (fft_sync_i && fft_ce_q) begin
                        // Sync wins over an expiring timeout; this cycle carries bin 0.
                        state_q     <= S_DRAIN;
                        fft_ce_q    <= 1'b1;
                        out_valid_q <= 1'b1;
                        out_re_q    <= fft_re_i;
                        out_im_q    <= fft_im_i;
                        out_bin_q   <= fft_cnt_i;
                        drain_cnt_q <= (FFT_NLOG2 + 1)'(1);
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_q  <= S_IDLE;
                        fft_ce_q <= 1'b0;
                        busy_q   <= 1'b0;
                        err_q    <= 1'b1;
                    end else begin
                        fft_ce_q  <= 1'b1;
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    fft_re_q <= '0;
                    if (drain_cnt_q == DRAIN_END) begin
                        // One extra cycle so done_o is seen while still busy.
                        state_q  <= S_IDLE;
                        fft_ce_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else begin
                        out_valid_q <= 1'b1;
                        out_re_q    <= fft_re_i;
                        out_im_q    <= fft_im_i;
                        out_bin_q   <= fft_cnt_i;
                        drain_cnt_q <= drain_cnt_q + 1'b1;
                        if (drain_cnt_q == DRAIN_LAST) begin
                            done_q   <= 1'b1;
                            fft_ce_q <= 1'b0;
                        end else begin
                            fft_ce_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    fft_ce_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign fft_ce_o    = fft_ce_q;
    assign fft_re_o    = fft_re_q;
    assign fft_im_o    = '0;
    assign out_valid_o = out_valid_q;
    assign out_re_o    = out_re_q;
    assign out_im_o    = out_im_q;
    assign out_bin_o   = out_bin_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl, with a small stand-in FFT that produces a known bin pattern.
module tb_fft_frame_ctrl;

    localparam int OW     = 12;
    localparam int FN     = 16;
    localparam int NL     = 4;
    localparam int FMAX   = 32;
    localparam int DW     = 5;
    localparam int LAT    = 3;
    localparam int BUDGET = 400;
    localparam int MAXOBS = 40;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          start_i = 1'b0;
    logic          in_valid_i = 1'b0;
    logic [OW-1:0] in_data_i = '0;
    logic          fft_ce_o;
    logic [OW-1:0] fft_re_o, fft_im_o;
    logic          fft_sync_i;
    logic [NL-1:0] fft_cnt_i;
    logic [OW-1:0] fft_re_i, fft_im_i;
    logic          out_valid_o;
    logic [OW-1:0] out_re_o, out_im_o;
    logic [NL-1:0] out_bin_o;
    logic          busy_o, done_o, err_o;
    logic [DW-1:0] drop_cnt_o;
    logic [1:0]    state_o;

    fft_frame_ctrl #(.OW(OW), .FFT_N(FN), .FFT_NLOG2(NL), .FLUSH_MAX(FMAX), .DROPW(DW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .in_valid_i(in_valid_i),
        .in_data_i(in_data_i), .fft_ce_o(fft_ce_o), .fft_re_o(fft_re_o), .fft_im_o(fft_im_o),
        .fft_sync_i(fft_sync_i), .fft_cnt_i(fft_cnt_i), .fft_re_i(fft_re_i), .fft_im_i(fft_im_i),
        .out_valid_o(out_valid_o), .out_re_o(out_re_o), .out_im_o(out_im_o),
        .out_bin_o(out_bin_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .drop_cnt_o(drop_cnt_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in FFT: counts enabled cycles; bin 0 appears LAT cycles after the N-th sample,
    // plus a spurious sync early in the fill. Bin b outputs re=100+7b, im=-3b.
    int ce_seen = 0;
    int k;
    bit sync_en = 1'b1;
    always @(posedge clk_i) begin
        if (!busy_o) ce_seen <= 0;
        else if (fft_ce_o) ce_seen <= ce_seen + 1;
    end
    always_comb begin
        k          = ce_seen - (FN + LAT);
        fft_sync_i = sync_en && ((k == 0) || (ce_seen == 2));
        fft_cnt_i  = k[NL-1:0];
        fft_re_i   = OW'(100 + 7 * k);
        fft_im_i   = OW'(-3 * k);
    end

    int vectors = 0;
    int errors  = 0;

    logic [OW-1:0] samp [FN];
    logic [OW-1:0] fed [FN+2];
    logic [OW-1:0] obs_re [MAXOBS];
    logic [OW-1:0] obs_im [MAXOBS];
    logic [NL-1:0] obs_bin [MAXOBS];
    int   n_fed, n_out, n_done, done_idx;
    bit   timed_out;
    logic busy_at_done, busy_after, valid_after, busy_after_start, err_after_start;
    logic [1:0] state_after_start;

    task automatic run_frame(input bit gap, input bit flush_drop, input int drain_drops,
                             input bit hold_start, input bit skip_start);
        int idx;
        int drops_left;
        int cyc;
        bit fd;
        bit seen_out;
        bit finished;
        idx = 0; drops_left = drain_drops; cyc = 0; fd = flush_drop; seen_out = 0; finished = 0;
        n_fed = 0; n_out = 0; n_done = 0; done_idx = -1; timed_out = 0; busy_at_done = 1'b0;
        for (int i = 0; i < FN + 2; i++) fed[i] = 'x;
        for (int i = 0; i < MAXOBS; i++) begin
            obs_re[i] = 'x; obs_im[i] = 'x; obs_bin[i] = 'x;
        end
        if (!skip_start) begin
            start_i = 1'b1;
            @(negedge clk_i);
            if (!hold_start) start_i = 1'b0;
            busy_after_start  = busy_o;
            err_after_start   = err_o;
            state_after_start = state_o;
        end
        while (!finished && cyc < BUDGET) begin
            if (idx < FN && !(gap && (cyc % 2) == 0)) begin
                in_valid_i = 1'b1; in_data_i = samp[idx]; idx++;
            end else if (idx == FN && fd) begin
                in_valid_i = 1'b1; in_data_i = OW'(1234); fd = 1'b0;
            end else if (seen_out && drops_left > 0) begin
                in_valid_i = 1'b1; in_data_i = '1; drops_left--;
            end else begin
                in_valid_i = 1'b0; in_data_i = '0;
            end
            @(negedge clk_i);
            cyc++;
            if (fft_ce_o && n_fed < FN + 2) begin
                fed[n_fed] = fft_re_o; n_fed++;
            end
            if (out_valid_o) begin
                seen_out = 1'b1;
                if (n_out < MAXOBS) begin
                    obs_re[n_out] = out_re_o; obs_im[n_out] = out_im_o; obs_bin[n_out] = out_bin_o;
                end
                n_out++;
            end
            if (done_o) begin
                n_done++;
                done_idx     = out_valid_o ? n_out - 1 : -1;
                busy_at_done = busy_o;
                finished     = 1'b1;
            end
        end
        in_valid_i = 1'b0; in_data_i = '0;
        if (!finished) timed_out = 1'b1;
        @(negedge clk_i);
        busy_after  = busy_o;
        valid_after = out_valid_o;
        start_i     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        vectors++;
        if ({fft_ce_o, out_valid_o, busy_o, done_o, err_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ce,vld,busy,done,err=%b, need 00000",
                     {fft_ce_o, out_valid_o, busy_o, done_o, err_o});
        end
        vectors++;
        if ({fft_re_o, fft_im_o, out_re_o, out_im_o, out_bin_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: fre=%0h fim=%0h ore=%0h oim=%0h bin=%0h, need all 0",
                     fft_re_o, fft_im_o, out_re_o, out_im_o, out_bin_o);
        end
        vectors++;
        if (drop_cnt_o !== '0 || state_o !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_cnt: drop=%0d state=%0d, need 0 0", drop_cnt_o, state_o);
        end
        rst_n_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_impulse();
        for (int i = 0; i < FN; i++) samp[i] = '0;
        samp[0] = OW'(1000);
        run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0);
        vectors++;
        if (busy_after_start !== 1'b1 || state_after_start !== ST_FILL) begin
            errors++;
            $display("FAIL impulse_start: busy=%0b state=%0d, need 1 %0d",
                     busy_after_start, state_after_start, ST_FILL);
        end
        vectors++;
        if (timed_out !== 1'b0) begin
            errors++; $display("FAIL impulse_budget: no done_o within %0d cycles", BUDGET);
        end
        for (int i = 0; i < FN + 2; i++) begin
            vectors++;
            if (fed[i] !== ((i < FN) ? samp[i] : OW'(0))) begin
                errors++;
                $display("FAIL impulse_fed%0d: got %0h need %0h", i, fed[i],
                         (i < FN) ? samp[i] : OW'(0));
            end
        end
        vectors++;
        if (n_out !== FN) begin
            errors++; $display("FAIL impulse_count: got %0d bins need %0d", n_out, FN);
        end
        for (int b = 0; b < FN; b++) begin
            vectors++;
            if (obs_bin[b] !== NL'(b) || obs_re[b] !== OW'(100 + 7 * b) || obs_im[b] !== OW'(-3 * b)) begin
                errors++;
                $display("FAIL impulse_bin%0d: got bin=%0d re=%0h im=%0h need bin=%0d re=%0h im=%0h",
                         b, obs_bin[b], obs_re[b], obs_im[b], b, OW'(100 + 7 * b), OW'(-3 * b));
            end
        end
        vectors++;
        if (n_done !== 1 || done_idx !== FN - 1) begin
            errors++;
            $display("FAIL impulse_done: pulses=%0d at idx=%0d need 1 at %0d", n_done, done_idx, FN - 1);
        end
        vectors++;
        if (busy_at_done !== 1'b1 || busy_after !== 1'b0 || valid_after !== 1'b0) begin
            errors++;
            $display("FAIL impulse_busy: at_done=%0b after=%0b vld_after=%0b need 1 0 0",
                     busy_at_done, busy_after, valid_after);
        end
        vectors++;
        if (err_o !== 1'b0 || drop_cnt_o !== '0) begin
            errors++; $display("FAIL impulse_flags: err=%0b drop=%0d need 0 0", err_o, drop_cnt_o);
        end
    endtask

    task automatic test_gapped();
        for (int i = 0; i < FN; i++) samp[i] = OW'(i * 113 - 800);
        run_frame(1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < FN + 2; i++) begin
            vectors++;
            if (fed[i] !== ((i < FN) ? samp[i] : OW'(0))) begin
                errors++;
                $display("FAIL gapped_fed%0d: got %0h need %0h", i, fed[i], (i < FN) ? samp[i] : OW'(0));
            end
        end
        vectors++;
        if (n_out !== FN || n_done !== 1 || done_idx !== FN - 1) begin
            errors++;
            $display("FAIL gapped_frame: bins=%0d done=%0d idx=%0d need %0d 1 %0d",
                     n_out, n_done, done_idx, FN, FN - 1);
        end
        for (int b = 0; b < FN; b++) begin
            vectors++;
            if (obs_bin[b] !== NL'(b) || obs_re[b] !== OW'(100 + 7 * b)) begin
                errors++;
                $display("FAIL gapped_bin%0d: got bin=%0d re=%0h need bin=%0d re=%0h",
                         b, obs_bin[b], obs_re[b], b, OW'(100 + 7 * b));
            end
        end
    endtask

    task automatic test_drops();
        for (int i = 0; i < FN; i++) samp[i] = OW'(3 * i + 1);
        in_valid_i = 1'b1; in_data_i = OW'(77);
        repeat (10) @(negedge clk_i);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (drop_cnt_o !== DW'(10)) begin
            errors++; $display("FAIL drops_idle: got %0d need 10", drop_cnt_o);
        end
        // One drop on the first FLUSH cycle, four during DRAIN.
        run_frame(1'b0, 1'b1, 4, 1'b0, 1'b0);
        vectors++;
        if (drop_cnt_o !== DW'(15)) begin
            errors++; $display("FAIL drops_frame: got %0d need 15", drop_cnt_o);
        end
        for (int i = 0; i < FN + 2; i++) begin
            vectors++;
            if (fed[i] !== ((i < FN) ? samp[i] : OW'(0))) begin
                errors++;
                $display("FAIL drops_fed%0d: got %0h need %0h", i, fed[i], (i < FN) ? samp[i] : OW'(0));
            end
        end
        vectors++;
        if (n_out !== FN || n_done !== 1 || done_idx !== FN - 1 || obs_re[FN-1] !== OW'(100 + 7 * (FN - 1))) begin
            errors++;
            $display("FAIL drops_frame_out: bins=%0d done=%0d idx=%0d last_re=%0h",
                     n_out, n_done, done_idx, obs_re[FN-1]);
        end
        in_valid_i = 1'b1;
        repeat (20) @(negedge clk_i);
        in_valid_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if (drop_cnt_o !== DW'(31)) begin
            errors++; $display("FAIL drops_saturate: got %0d need 31", drop_cnt_o);
        end
    endtask

    task automatic test_timeout();
        int  cnt;
        int  stray;
        for (int i = 0; i < FN; i++) samp[i] = OW'(i);
        sync_en = 1'b0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < FN; i++) begin
            in_valid_i = 1'b1; in_data_i = samp[i];
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        vectors++;
        if (state_o !== ST_FLUSH) begin
            errors++; $display("FAIL timeout_entry: state=%0d need %0d", state_o, ST_FLUSH);
        end
        cnt = 0; stray = 0;
        while (err_o !== 1'b1 && cnt < FMAX + 10) begin
            @(negedge clk_i);
            cnt++;
            if (done_o || out_valid_o) stray++;
        end
        vectors++;
        if (cnt !== FMAX) begin
            errors++; $display("FAIL timeout_cycles: err after %0d cycles need %0d", cnt, FMAX);
        end
        vectors++;
        if (state_o !== ST_IDLE || busy_o !== 1'b0 || stray !== 0) begin
            errors++;
            $display("FAIL timeout_state: state=%0d busy=%0b stray=%0d need 0 0 0", state_o, busy_o, stray);
        end
        repeat (3) @(negedge clk_i);
        vectors++;
        if (err_o !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky: err=%0b need 1", err_o);
        end
        sync_en = 1'b1;
        run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0);
        vectors++;
        if (err_after_start !== 1'b0) begin
            errors++; $display("FAIL timeout_clear: err=%0b need 0", err_after_start);
        end
        vectors++;
        if (n_out !== FN || n_done !== 1 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_next: bins=%0d done=%0d err=%0b need %0d 1 0", n_out, n_done, err_o, FN);
        end
    endtask

    task automatic test_reset_mid_drain();
        int  cnt;
        int  stray;
        bit  found;
        for (int i = 0; i < FN; i++) samp[i] = OW'(50 - i);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < FN; i++) begin
            in_valid_i = 1'b1; in_data_i = samp[i];
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        found = 1'b0; cnt = 0;
        while (!found && cnt < 100) begin
            @(negedge clk_i);
            cnt++;
            if (out_valid_o && out_bin_o == NL'(8)) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            errors++; $display("FAIL rstmid_reach: bin 8 not seen within 100 cycles");
        end
        rst_n_i = 1'b0;
        @(negedge clk_i);
        vectors++;
        if ({fft_ce_o, out_valid_o, busy_o, done_o, err_o} !== 5'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl: ce,vld,busy,done,err=%b need 00000",
                     {fft_ce_o, out_valid_o, busy_o, done_o, err_o});
        end
        vectors++;
        if ({fft_re_o, out_re_o, out_im_o, out_bin_o} !== '0 || drop_cnt_o !== '0 || state_o !== ST_IDLE) begin
            errors++;
            $display("FAIL rstmid_data: fre=%0h ore=%0h oim=%0h bin=%0d drop=%0d state=%0d need all 0",
                     fft_re_o, out_re_o, out_im_o, out_bin_o, drop_cnt_o, state_o);
        end
        rst_n_i = 1'b1;
        stray = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (done_o || err_o || out_valid_o || busy_o) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            errors++; $display("FAIL rstmid_quiet: %0d active cycles after reset need 0", stray);
        end
        run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0);
        vectors++;
        if (n_out !== FN || n_done !== 1 || done_idx !== FN - 1) begin
            errors++;
            $display("FAIL rstmid_next: bins=%0d done=%0d idx=%0d need %0d 1 %0d",
                     n_out, n_done, done_idx, FN, FN - 1);
        end
        for (int b = 0; b < FN; b++) begin
            vectors++;
            if (obs_bin[b] !== NL'(b) || obs_im[b] !== OW'(-3 * b)) begin
                errors++;
                $display("FAIL rstmid_bin%0d: got bin=%0d im=%0h need bin=%0d im=%0h",
                         b, obs_bin[b], obs_im[b], b, OW'(-3 * b));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < FN; i++) samp[i] = OW'(i * 9);
        // start_i held through the done cycle: one frame, no restart.
        run_frame(1'b0, 1'b0, 0, 1'b1, 1'b0);
        vectors++;
        if (n_out !== FN || n_done !== 1) begin
            errors++; $display("FAIL hold_frame: bins=%0d done=%0d need %0d 1", n_out, n_done, FN);
        end
        vectors++;
        if (busy_after !== 1'b0) begin
            errors++; $display("FAIL hold_done_start: busy=%0b need 0", busy_after);
        end
        @(negedge clk_i);
        vectors++;
        if (busy_o !== 1'b0 || state_o !== ST_IDLE) begin
            errors++; $display("FAIL hold_idle: busy=%0b state=%0d need 0 0", busy_o, state_o);
        end
        run_frame(1'b0, 1'b0, 0, 1'b0, 1'b0);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        vectors++;
        if (state_o !== ST_FILL || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_fill: state=%0d busy=%0b need %0d 1 two cycles after done", state_o, busy_o, ST_FILL);
        end
        run_frame(1'b0, 1'b0, 0, 1'b0, 1'b1);
        vectors++;
        if (n_out !== FN || n_done !== 1 || done_idx !== FN - 1 || fed[FN-1] !== samp[FN-1]) begin
            errors++;
            $display("FAIL b2b_frame: bins=%0d done=%0d idx=%0d last_fed=%0h", n_out, n_done, done_idx, fed[FN-1]);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_gapped();
        test_drops();
        test_timeout();
        test_reset_mid_drain();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
